// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter that shares one single-port, variable-latency memory
// between NUM_REQ cache requesters. One access is in flight at a time; the
// completion pulse goes only to the requester that was granted.
//
// Optional feature (compile-time macro): MEM_ARB_TIMEOUT_EN
//   Defined   : an access outstanding for TIMEOUT BUSY cycles is aborted and
//               completes with req_err=1; timeout_err becomes sticky.
//   Undefined : BUSY waits indefinitely; req_err and timeout_err are 0.
//
// Ports
//   clk, rst         : single clock, synchronous active-high reset
//   req_valid/we     : per-requester request strobe and write enable
//   req_addr/wdata   : packed per-requester fields, requester i at [i*W +: W]
//   req_ready        : one-cycle completion pulse, at most one bit set
//   req_rdata        : read data, valid while req_ready is high
//   req_err          : high with req_ready when the access timed out
//   mem_req/we/addr/wdata : registered memory request
//   mem_ready/rdata  : memory completion pulse and read data
//   timeout_err      : sticky timeout flag, cleared only by rst
//   dbg_state        : current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a requester raises req_valid with stable fields and holds them
// until its req_ready pulse. The memory sees mem_req held high with stable
// fields until it returns a single-cycle mem_ready.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [DATA_W-1:0]    req_rdata_q, req_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        timer_q, timer_d;
    logic                 req_err_q, req_err_d;
    logic                 timeout_err_q, timeout_err_d;
`endif

    // Round-robin pick: scan starting one past the last completed grant so
    // the most recently served requester has lowest priority.
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] cand_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req_ready_d  = '0;          // pulse lives only in DONE
        req_rdata_d  = req_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        timer_d       = timer_q;
        req_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we[pick_idx];
                    mem_addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d     = S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        req_rdata_d = mem_rdata;
                    end
                    mem_req_d            = 1'b0;
                    req_ready_d[grant_q] = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = S_DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT)) begin
                    // Abort: complete with error, read data left unchanged.
                    mem_req_d            = 1'b0;
                    req_ready_d[grant_q] = 1'b1;
                    req_err_d            = 1'b1;
                    timeout_err_d        = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            // DONE swallows one cycle so the finished requester's still-high
            // req_valid is dropped before IDLE samples again.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req_ready_q  <= '0;
            req_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q       <= '0;
            req_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            req_ready_q  <= req_ready_d;
            req_rdata_q  <= req_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q       <= timer_d;
            req_err_q     <= req_err_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign req_ready = req_ready_q;
    assign req_rdata = req_rdata_q;
    assign dbg_state = state_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign req_err     = req_err_q;
    assign timeout_err = timeout_err_q;
`else
    assign req_err     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios plus randomized multi-requester traffic for mem_arbiter.
// A negedge monitor predicts every grant from the round-robin rule applied to
// the requests it saw, and predicts each completion's read data from a shadow
// copy of memory. A simple variable-latency memory answers mem_req.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_err;
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_ready;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      timeout_err;
    logic [1:0]                dbg_state;

    logic        drv_valid [NUM_REQ];
    logic        drv_we    [NUM_REQ];
    logic [31:0] drv_addr  [NUM_REQ];
    logic [31:0] drv_wdata [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]                 = drv_valid[i];
            req_we[i]                    = drv_we[i];
            req_addr[i*ADDR_W +: ADDR_W] = drv_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = drv_wdata[i];
        end
    end

    mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
        .req_err(req_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [256];
    logic [31:0] shadow  [256];
    bit mem_en   = 1'b1;
    bit mem_rand = 1'b0;
    int mem_lat  = 10;
    int mcnt     = 0;
    int cur_lat  = 1;

    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mcnt = 0;
        end else begin
            mem_ready <= 1'b0;
            if (mem_req && !mem_ready && mem_en) begin
                if (mcnt == 0) cur_lat = mem_rand ? int'($urandom_range(1, 5)) : mem_lat;
                mcnt++;
                if (mcnt == cur_lat) begin
                    mcnt = 0;
                    mem_ready <= 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr[9:2]] = mem_wdata;
                        mem_rdata <= $urandom;   // garbage: must not reach req_rdata
                    end else begin
                        mem_rdata <= mem_arr[mem_addr[9:2]];
                    end
                end
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]         exp_q[$];      // granted requester, in grant order
    int                 grant_log[$];  // completions, in order
    int                 last_m = NUM_REQ - 1;
    logic [NUM_REQ-1:0] valid_prev = '0;
    logic               mem_req_prev = 1'b0;
    int                 low_run = 2;
    int                 rises = 0;
    int                 hi_cnt = 0;
    int                 rise_cyc = 0;
    logic [31:0]        exp_rdata = '0;
    bit                 to_mode = 1'b0;

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        if (rst) begin
            last_m       = NUM_REQ - 1;
            exp_q.delete();
            mem_req_prev = 1'b0;
            low_run      = 2;
            exp_rdata    = '0;
        end else begin
            if (mem_req && !mem_req_prev) begin
                rises++;
                rise_cyc = cyc;
                check("mem_req_gap", 64'(low_run >= 2), 64'd1);
                w = rr_pick(last_m, valid_prev);
                if (w < 0) begin
                    check("grant_without_request", 64'(mem_req), 64'd0);
                end else begin
                    check("mem_we", 64'(mem_we), 64'(drv_we[w]));
                    check("mem_addr", 64'(mem_addr), 64'(drv_addr[w]));
                    check("mem_wdata", 64'(mem_wdata), 64'(drv_wdata[w]));
                    exp_q.push_back(8'(w));
                end
            end
            if (mem_req) begin
                hi_cnt++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 64'(req_ready), 64'd0);
                end else begin
                    w = int'(exp_q.pop_front());
                    check("req_ready_onehot", 64'(req_ready), 64'(1) << w);
                    if (to_mode) begin
                        check("req_err_timeout", 64'(req_err), 64'd1);
                        check("rdata_after_timeout", 64'(req_rdata), 64'(exp_rdata));
                    end else begin
                        check("req_err", 64'(req_err), 64'd0);
                        if (drv_we[w]) begin
                            check("rdata_after_write", 64'(req_rdata), 64'(exp_rdata));
                            shadow[drv_addr[w][9:2]] = drv_wdata[w];
                        end else begin
                            exp_rdata = shadow[drv_addr[w][9:2]];
                            check("read_data", 64'(req_rdata), 64'(exp_rdata));
                        end
                    end
                    last_m = w;
                    grant_log.push_back(w);
                end
            end
            mem_req_prev = mem_req;
        end
        valid_prev = req_valid;
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns cycles from request to req_ready.
    task automatic do_req(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        int start;
        int n;
        drv_we[id]    = we;
        drv_addr[id]  = addr;
        drv_wdata[id] = wdata;
        drv_valid[id] = 1'b1;
        start = cyc;
        n     = 0;
        lat   = -1;
        rd    = '0;
        while (n < 500) begin
            @(posedge clk); #1;
            n++;
            if (req_ready[id]) begin
                lat = cyc - start;
                rd  = req_rdata;
                break;
            end
        end
        if (lat < 0) check("ready_wait_expired", 64'(req_ready[id]), 64'd1);
        drv_valid[id] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) drv_valid[i] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_req_rdata", 64'(req_rdata), 64'd0);
        check("rst_req_err", 64'(req_err), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        rst = 1'b0;
    endtask

    task automatic rand_driver(input int id);
        int lat;
        logic [31:0] rd;
        logic [31:0] addr;
        repeat (10) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            do_req(id, 1'($urandom_range(0, 1)), addr, $urandom, lat, rd);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'(i);
            shadow[i]  = 32'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_valid[i] = 1'b0;
            drv_we[i]    = 1'b0;
            drv_addr[i]  = '0;
            drv_wdata[i] = '0;
        end
        mem_rdata = '0;
        @(posedge clk); #1;
        do_reset();

        // Single uncontended read, latency 10.
        mem_lat = 10;
        hi_cnt  = 0;
        do_req(0, 1'b0, 32'h40, 32'h0, lat, rd);
        check("single_latency", 64'(lat), 64'd12);
        check("single_rdata", 64'(rd), 64'h10);
        check("single_mem_req_cycles", 64'(hi_cnt), 64'd11);

        // Write then read from requester 1.
        do_req(1, 1'b1, 32'h80, 32'hDEADBEEF, lat, rd);
        check("write_rdata_unchanged", 64'(rd), 64'h10);
        do_req(1, 1'b0, 32'h80, 32'h0, lat, rd);
        check("readback", 64'(rd), 64'hDEADBEEF);

        // Simultaneous requests after reset.
        do_reset();
        mem_lat = 4;
        rises   = 0;
        grant_log.delete();
        fork
            do_req(0, 1'b0, 32'h44, 32'h0, lat, rd);
            begin
                int l1;
                logic [31:0] r1;
                do_req(1, 1'b0, 32'h48, 32'h0, l1, r1);
            end
        join
        check("simul_rises", 64'(rises), 64'd2);
        check("simul_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check("simul_first", 64'(grant_log[0]), 64'd0);
            check("simul_second", 64'(grant_log[1]), 64'd1);
        end

        // Fairness: both hold requests for 6 accesses.
        do_reset();
        mem_lat = 3;
        grant_log.delete();
        fork
            begin
                int l0;
                logic [31:0] r0;
                repeat (3) do_req(0, 1'b0, 32'h10, 32'h0, l0, r0);
            end
            begin
                int l1;
                logic [31:0] r1;
                repeat (3) do_req(1, 1'b0, 32'h14, 32'h0, l1, r1);
            end
        join
        check("fair_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < grant_log.size(); i++) begin
            check($sformatf("fair_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
        end

        // Reset in cycle 5 of an access abandons it with no pulse.
        do_reset();
        mem_lat = 10;
        drv_we[0]    = 1'b0;
        drv_addr[0]  = 32'h40;
        drv_valid[0] = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst          = 1'b1;
        drv_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_pulse", 64'(req_ready), 64'd0);
        end
        do_req(0, 1'b0, 32'h40, 32'h0, lat, rd);
        check("post_rst_latency", 64'(lat), 64'd12);
        check("post_rst_rdata", 64'(rd), 64'h10);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort after TIMEOUT BUSY cycles.
        do_reset();
        mem_en  = 1'b0;
        to_mode = 1'b1;
        do_req(0, 1'b0, 32'h40, 32'h0, lat, rd);
        check("timeout_latency", 64'(lat), 64'd18);
        check("timeout_rdata", 64'(rd), 64'd0);
        check("timeout_flag", 64'(timeout_err), 64'd1);
        to_mode = 1'b0;
        mem_en  = 1'b1;
        mem_lat = 2;
        do_req(1, 1'b0, 32'h44, 32'h0, lat, rd);
        check("timeout_flag_sticky", 64'(timeout_err), 64'd1);
        do_reset();
`endif

        // Randomized traffic on all requesters with random memory latency.
        do_reset();
        mem_rand = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            automatic int id = i;
            fork
                rand_driver(id);
            join_none
        end
        wait fork;
        repeat (4) begin @(posedge clk); #1; end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("timeout_err_final", 64'(timeout_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
